// File: rtl/sprite_blit.sv
// sprite_blit: copies one SPR_W x SPR_H sprite from ROM into the framebuffer with clipping and flips.
// Optional colour-key transparency on rom_data[24] is enabled by defining SPRITE_BLIT_TRANSPARENCY_EN.
module sprite_blit #(
    parameter  int SPR_W  = 8,
    parameter  int SPR_H  = 8,
    parameter  int IMG_W  = 8,
    parameter  int FB_W   = 320,
    parameter  int FB_H   = 240,
    parameter  int FB_AW  = 17,
    localparam int CW     = $clog2(SPR_W),
    localparam int RW     = $clog2(SPR_H),
    localparam int ROM_AW = IMG_W + RW + CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        x_pos,
    input  logic [8:0]        y_pos,
    input  logic [IMG_W-1:0]  img_sel,
    input  logic              flip_h,
    input  logic              flip_v,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              read_en,
    input  logic [31:0]       rom_data,
    input  logic              rom_data_valid,
    output logic [FB_AW-1:0]  frame_addr,
    output logic [23:0]       frame_data,
    output logic              write_en,
    input  logic              frame_write_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [9:0]       x_lat;
    logic [8:0]       y_lat;
    logic [IMG_W-1:0] img_lat;
    logic             flip_h_lat, flip_v_lat;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;

    logic [10:0]      x_abs;
    logic [9:0]       y_abs;
    logic [CW-1:0]    rom_col;
    logic [RW-1:0]    rom_row;
    logic             clipped, last_pix, pix_transparent;
    logic             accept, advance, load_pix;
    logic             unused_flags;

    // Widened sums so a sprite hanging past the right/bottom edge never wraps back into range.
    assign x_abs      = 11'(x_lat) + 11'(col);
    assign y_abs      = 10'(y_lat) + 10'(row);
    assign clipped    = (x_abs >= 11'(FB_W)) || (y_abs >= 10'(FB_H));
    assign frame_addr = FB_AW'(y_abs) * FB_AW'(FB_W) + FB_AW'(x_abs);

    // Sizes are powers of two, so SIZE-1-n is the bitwise complement and all-ones marks the last index.
    assign rom_col  = flip_h_lat ? ~col : col;
    assign rom_row  = flip_v_lat ? ~row : row;
    assign rom_addr = {img_lat, rom_row, rom_col};
    assign last_pix = (&col) && (&row);
    assign busy     = (state != S_IDLE);

`ifdef SPRITE_BLIT_TRANSPARENCY_EN
    assign pix_transparent = rom_data[24];
    assign unused_flags    = ^rom_data[31:25];
`else
    assign pix_transparent = 1'b0;
    assign unused_flags    = ^rom_data[31:24];
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        read_en    = 1'b0;
        write_en   = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        load_pix   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_READ;
                end
            end
            S_READ: begin
                if (clipped) begin
                    advance = 1'b1;
                end else begin
                    read_en = 1'b1;
                    if (rom_data_valid) begin
                        if (pix_transparent) begin
                            advance = 1'b1;
                        end else begin
                            load_pix   = 1'b1;
                            state_next = S_WRITE;
                        end
                    end
                end
            end
            S_WRITE: begin
                write_en = 1'b1;
                if (frame_write_valid) advance = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        if (advance) state_next = last_pix ? S_IDLE : S_READ;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat      <= '0;
            y_lat      <= '0;
            img_lat    <= '0;
            flip_h_lat <= 1'b0;
            flip_v_lat <= 1'b0;
            col        <= '0;
            row        <= '0;
            done       <= 1'b0;
            frame_data <= '0;
        end else begin
            if (accept) begin
                x_lat      <= x_pos;
                y_lat      <= y_pos;
                img_lat    <= img_sel;
                flip_h_lat <= flip_h;
                flip_v_lat <= flip_v;
                col        <= '0;
                row        <= '0;
                done       <= 1'b0;
            end
            if (load_pix) frame_data <= rom_data[23:0];
            if (advance) begin
                if (last_pix) begin
                    col  <= '0;
                    row  <= '0;
                    done <= 1'b1;
                end else if (&col) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule
